// File: rtl/aes_pkg.sv
// AES S-box tables, lookup helper and the SubBytes engine state encoding.
// The inverse table is only referenced (and thus only synthesised) when INV_SBOX_EN is defined.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane: byte in, substituted byte out, zero latency.
// With INV_SBOX_EN defined an inv input selects the inverse table; otherwise forward only.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
`ifdef INV_SBOX_EN
  input  logic       inv,
`endif
  output logic [7:0] out_byte
);

`ifdef INV_SBOX_EN
  assign out_byte = sbox_f(in_byte, inv);
`else
  assign out_byte = sbox_f(in_byte, 1'b0);
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES bytes per cycle, NBYTES/LANES cycles from accept to out_valid (INV_SBOX_EN adds inv).
// Result is held in DONE until out_ready; a new block may be accepted on the same edge the result is consumed.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:8*NBYTES-1] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:8*NBYTES-1] out_data,
  output logic                busy
`ifdef INV_SBOX_EN
  ,
  input  logic                inv
`endif
);

  localparam int ITER = NBYTES / LANES;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  state_e              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [0:8*NBYTES-1] work;
  logic [0:8*LANES-1]  lane_out;
  logic                accept;
  logic                last_beat;

`ifdef INV_SBOX_EN
  logic inv_q;
`endif

  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CW'(ITER - 1));
  assign out_data  = work;

  // Each lane reads its byte of the current group straight out of the work register.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .in_byte  (work[(int'(cnt) * LANES + i) * 8 +: 8]),
`ifdef INV_SBOX_EN
      .inv      (inv_q),
`endif
      .out_byte (lane_out[8*i +: 8])
    );
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
`ifdef INV_SBOX_EN
      inv_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        work  <= in_data;
        cnt   <= '0;
`ifdef INV_SBOX_EN
        inv_q <= inv;
`endif
      end else if (state == BUSY) begin
        work[int'(cnt) * 8 * LANES +: 8 * LANES] <= lane_out;
        cnt <= last_beat ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: four instances (LANES 1/2/4/16) against a GF(2^8) reference S-box model.
// Instance 2 (LANES=4) carries the scoreboard for the backpressure, reset and randomised sweep scenarios.
module tb_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [0:127] in_data   [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [0:127] out_data  [4];
  logic         busy      [4];
`ifdef INV_SBOX_EN
  logic         inv       [4];
`endif

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  bit done_drv;
  logic [7:0]   ref_sbox [256];
  logic [7:0]   ref_inv  [256];
  logic [0:127] sb_q [$];

  localparam logic [0:127] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    sub_bytes_iter #(.NBYTES(16), .LANES(LN)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
`ifdef INV_SBOX_EN
      ,
      .inv       (inv[g])
`endif
    );
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_ref();
    logic [7:0] iv;
    for (int b = 0; b < 256; b++) begin
      iv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gf_mul(8'(b), 8'(x)) == 8'h01) iv = 8'(x);
      ref_sbox[b] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int b = 0; b < 256; b++) ref_inv[ref_sbox[b]] = 8'(b);
  endtask

  function automatic logic [0:127] sub_model(input logic [0:127] blk, input logic use_inv);
    logic [0:127] r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = use_inv ? ref_inv[blk[8*k +: 8]] : ref_sbox[blk[8*k +: 8]];
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input logic [0:127] blk, input logic use_inv);
    int n;
    in_data[d]  = blk;
`ifdef INV_SBOX_EN
    inv[d]      = use_inv;
`endif
    in_valid[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut=%0d in_ready=%b required 1", d, in_ready[d]);
    end else if (d == 2) begin
      sb_q.push_back(sub_model(blk, use_inv));
    end
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid[2] === 1'b1 && out_ready[2] === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected out_data=%h with empty scoreboard", out_data[2]);
      end else begin
        logic [0:127] exp;
        exp = sb_q.pop_front();
        if (out_data[2] !== exp) begin
          errors++;
          $display("FAIL sb_data got=%h required=%h", out_data[2], exp);
        end
      end
      n_out++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks += 4;
      if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut=%0d got=%b required=1", d, in_ready[d]); end
      if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut=%0d got=%b required=0", d, out_valid[d]); end
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut=%0d got=%b required=0", d, busy[d]); end
      if (out_data[d] !== 128'h0) begin errors++; $display("FAIL reset_out_data dut=%0d got=%h required=0", d, out_data[d]); end
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fips();
    int n;
    send(2, FIPS_IN, 1'b0);
    n = 0;
    while (out_valid[2] !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
    checks += 2;
    if (n != 4) begin errors++; $display("FAIL fips_latency got=%0d required=4", n); end
    if (out_data[2] !== FIPS_OUT) begin errors++; $display("FAIL fips_data got=%h required=%h", out_data[2], FIPS_OUT); end
    @(posedge clk); #1;
  endtask

  task automatic test_lanes();
    int d, lat, n;
    for (int j = 0; j < 3; j++) begin
      d   = (j == 0) ? 0 : (j == 1) ? 1 : 3;
      lat = (j == 0) ? 16 : (j == 1) ? 8 : 1;
      send(d, FIPS_IN, 1'b0);
      n = 0;
      while (out_valid[d] !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
      checks += 2;
      if (n != lat) begin errors++; $display("FAIL lanes_latency dut=%0d got=%0d required=%0d", d, n, lat); end
      if (out_data[d] !== FIPS_OUT) begin errors++; $display("FAIL lanes_data dut=%0d got=%h required=%h", d, out_data[d], FIPS_OUT); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] blk_a, blk_b, exp_a, exp_b;
    int n;
    blk_a = 128'hdeadbeef0123456789abcdeffedcba98;
    blk_b = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    exp_a = sub_model(blk_a, 1'b0);
    exp_b = sub_model(blk_b, 1'b0);
    out_ready[2] = 1'b0;
    send(2, blk_a, 1'b0);
    n = 0;
    while (out_valid[2] !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
    in_data[2]  = blk_b;
    in_valid[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 3;
      if (out_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b required=1", i, out_valid[2]); end
      if (out_data[2] !== exp_a) begin errors++; $display("FAIL bp_out_data cyc=%0d got=%h required=%h", i, out_data[2], exp_a); end
      if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b required=0", i, in_ready[2]); end
    end
    @(posedge clk);
    #1 out_ready[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready[2] !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b required=1", in_ready[2]); end
    sb_q.push_back(exp_b);
    @(posedge clk);
    #1 in_valid[2] = 1'b0;
    checks += 2;
    if (busy[2] !== 1'b1) begin errors++; $display("FAIL bp_same_cycle_accept busy=%b required=1", busy[2]); end
    if (out_valid[2] !== 1'b0) begin errors++; $display("FAIL bp_consumed out_valid=%b required=0", out_valid[2]); end
    n = 0;
    while (out_valid[2] !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
    checks++;
    if (out_data[2] !== exp_b) begin errors++; $display("FAIL bp_second_data got=%h required=%h", out_data[2], exp_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [0:127] blk;
    int n;
    send(2, 128'h1111111122222222333333334444444f, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    checks += 4;
    if (in_ready[2] !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b required=1", in_ready[2]); end
    if (out_valid[2] !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b required=0", out_valid[2]); end
    if (busy[2] !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b required=0", busy[2]); end
    if (out_data[2] !== 128'h0) begin errors++; $display("FAIL midrst_out_data got=%h required=0", out_data[2]); end
    blk = 128'h8899aabbccddeeff0011223344556677;
    send(2, blk, 1'b0);
    n = 0;
    while (out_valid[2] !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
    checks++;
    if (out_data[2] !== sub_model(blk, 1'b0)) begin
      errors++;
      $display("FAIL midrst_next_block got=%h required=%h", out_data[2], sub_model(blk, 1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_inv();
    logic [0:127] exp;
    int n;
`ifdef INV_SBOX_EN
    exp = FIPS_IN;
    send(2, FIPS_OUT, 1'b1);
`else
    exp = sub_model(FIPS_OUT, 1'b0);
    send(2, FIPS_OUT, 1'b0);
`endif
    n = 0;
    while (out_valid[2] !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
    checks++;
    if (out_data[2] !== exp) begin errors++; $display("FAIL inv_data got=%h required=%h", out_data[2], exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive();
    int start_out, n;
    start_out = n_out;
    done_drv  = 1'b0;
    fork
      begin
        logic [0:127] blk;
        for (int j = 0; j < 16; j++) begin
          for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(j * 16 + k);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send(2, blk, 1'b0);
        end
        done_drv = 1'b1;
      end
      begin
        while (!done_drv) begin
          @(posedge clk);
          #1 out_ready[2] = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready[2] = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n_out - start_out != 16) begin
      errors++;
      $display("FAIL exhaustive_count got=%0d required=16", n_out - start_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 4; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
`ifdef INV_SBOX_EN
      inv[d]       = 1'b0;
`endif
    end
    build_ref();
    test_reset();
    test_fips();
    test_lanes();
    test_backpressure();
    test_reset_mid();
    test_inv();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
